ram_write_ctrl: RTL and testbench

- Downstream consumer of the 32-bit incrementing data generator.
- Requests one 64-word packet at a time by pulsing the generator's start input.
- Captures each valid word and writes it into a multi-slot packet RAM, organised as a ring of fixed-size packet slots.
- Tracks slot occupancy against a downstream reader and stops requesting packets when the RAM is full.

---
 rtl/ram_sys_pkg.sv | 20 ++
 rtl/ram_slot_tracker.sv | 47 ++++
 rtl/ram_write_ctrl.sv | 129 ++++++++++++
 tb/tb_ram_write_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sys_pkg.sv
// Shared constants for the packet RAM write path: data/packet geometry,
// derived address widths and the write-controller state encoding.
package ram_sys_pkg;

  localparam int DATA_W    = 32;
  localparam int PKT_LEN   = 64;
  localparam int NUM_SLOTS = 4;

  localparam int WORD_W = $clog2(PKT_LEN);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int ADDR_W = $clog2(PKT_LEN * NUM_SLOTS);
  localparam int OCC_W  = SLOT_W + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/ram_slot_tracker.sv
// Ring-slot bookkeeping for the packet RAM: current write slot, number of
// filled slots, full flag and detection of a reader release while empty.
module ram_slot_tracker #(
  parameter  int NUM_SLOTS = ram_sys_pkg::NUM_SLOTS,
  localparam int SLOT_W    = $clog2(NUM_SLOTS),
  localparam int OCC_W     = SLOT_W + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pkt_done,
  input  logic              i_rd_done,
  output logic [SLOT_W-1:0] o_wr_slot,
  output logic [OCC_W-1:0]  o_occupancy,
  output logic              o_full,
  output logic              o_underflow
);

  logic [OCC_W-1:0] occ_nxt;

  // Release with nothing stored; a simultaneous fill cancels it out instead.
  assign o_underflow = i_rd_done && !i_pkt_done && (o_occupancy == '0);

  // Next occupancy: fill and release in the same cycle leave the count alone.
  always_comb begin
    occ_nxt = o_occupancy;
    if (i_pkt_done && !i_rd_done)
      occ_nxt = o_occupancy + 1'b1;
    else if (i_rd_done && !i_pkt_done && (o_occupancy != '0))
      occ_nxt = o_occupancy - 1'b1;
  end

  // Slot pointer, occupancy and full flag registers; the slot pointer wraps
  // naturally because NUM_SLOTS is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_slot   <= '0;
      o_occupancy <= '0;
      o_full      <= 1'b0;
    end else begin
      o_occupancy <= occ_nxt;
      o_full      <= (occ_nxt == OCC_W'(NUM_SLOTS));
      if (i_pkt_done)
        o_wr_slot <= o_wr_slot + 1'b1;
    end
  end

endmodule

// File: rtl/ram_write_ctrl.sv
// Packet RAM write controller: requests one packet at a time from the data
// generator, writes each valid word into the current ring slot and stops
// requesting while every slot is filled.
// Optional macro RAM_WR_PARITY_EN adds o_ram_wpar, the XOR parity of
// o_ram_wdata, registered with it.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_IDLE  | waiting for enable and a free slot
//   ST_REQ   | start pulse to the generator
//   ST_WAIT  | waiting for the first valid word (word 0)
//   ST_WRITE | writing words 1..PKT_LEN-1, gaps in valid tolerated
//   ST_DONE  | packet complete, slot handed to the tracker
module ram_write_ctrl #(
  parameter  int DATA_W    = ram_sys_pkg::DATA_W,
  parameter  int PKT_LEN   = ram_sys_pkg::PKT_LEN,
  parameter  int NUM_SLOTS = ram_sys_pkg::NUM_SLOTS,
  localparam int ADDR_W    = $clog2(PKT_LEN * NUM_SLOTS),
  localparam int OCC_W     = $clog2(NUM_SLOTS) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_rd_done,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_gen_start,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_pkt_done,
  output logic [OCC_W-1:0]  o_occupancy,
  output logic              o_full,
  output logic              o_busy,
  output logic              o_err
`ifdef RAM_WR_PARITY_EN
  ,
  output logic              o_ram_wpar
`endif
);

  import ram_sys_pkg::*;

  localparam int WORD_W = $clog2(PKT_LEN);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [WORD_W-1:0] word_cnt;
  logic [SLOT_W-1:0] wr_slot;
  logic              accept;
  logic              last_word;
  logic              proto_err;
  logic              underflow;
  logic              in_done;

  assign in_done   = (state == ST_DONE);
  assign accept    = i_data_valid && ((state == ST_WAIT) || (state == ST_WRITE));
  assign last_word = accept && (word_cnt == WORD_W'(PKT_LEN - 1));
  // Valid outside the collection window is dropped and flagged.
  assign proto_err = i_data_valid &&
                     ((state == ST_IDLE) || (state == ST_REQ) || (state == ST_DONE));

  ram_slot_tracker #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_slot_tracker (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_pkt_done  (in_done),
    .i_rd_done   (i_rd_done),
    .o_wr_slot   (wr_slot),
    .o_occupancy (o_occupancy),
    .o_full      (o_full),
    .o_underflow (underflow)
  );

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_enable && !o_full) state_nxt = ST_REQ;
      ST_REQ:   state_nxt = ST_WAIT;
      ST_WAIT,
      ST_WRITE: if (accept) state_nxt = last_word ? ST_DONE : ST_WRITE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, word counter and registered outputs; status outputs are decoded
  // from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      word_cnt    <= '0;
      o_gen_start <= 1'b0;
      o_pkt_done  <= 1'b0;
      o_busy      <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_gen_start <= (state_nxt == ST_REQ);
      o_pkt_done  <= (state_nxt == ST_DONE);
      o_busy      <= (state_nxt != ST_IDLE);
      o_ram_we    <= accept;
      if (accept) begin
        o_ram_addr  <= {wr_slot, word_cnt};
        o_ram_wdata <= i_data;
        word_cnt    <= last_word ? '0 : word_cnt + 1'b1;
      end
      if (proto_err || underflow)
        o_err <= 1'b1;
    end
  end

`ifdef RAM_WR_PARITY_EN
  // Parity travels with the write data it covers.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_ram_wpar <= 1'b0;
    else if (accept)
      o_ram_wpar <= ^i_data;
  end
`endif

endmodule

// File: tb/tb_ram_write_ctrl.sv
// Bench for ram_write_ctrl: models the incrementing generator and checks the
// write stream, packet pulses, occupancy and error flag every cycle.
module tb_ram_write_ctrl;
  import ram_sys_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic        i_rd_done;
  logic        i_data_valid;
  logic [31:0] i_data;
  logic        o_gen_start;
  logic        o_ram_we;
  logic [7:0]  o_ram_addr;
  logic [31:0] o_ram_wdata;
  logic        o_pkt_done;
  logic [2:0]  o_occupancy;
  logic        o_full;
  logic        o_busy;
  logic        o_err;
`ifdef RAM_WR_PARITY_EN
  logic        o_ram_wpar;
`endif

  always #5 i_clk = ~i_clk;

  ram_write_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_rd_done    (i_rd_done),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .o_gen_start  (o_gen_start),
    .o_ram_we     (o_ram_we),
    .o_ram_addr   (o_ram_addr),
    .o_ram_wdata  (o_ram_wdata),
    .o_pkt_done   (o_pkt_done),
    .o_occupancy  (o_occupancy),
    .o_full       (o_full),
    .o_busy       (o_busy),
    .o_err        (o_err)
`ifdef RAM_WR_PARITY_EN
    ,
    .o_ram_wpar   (o_ram_wpar)
`endif
  );

  typedef struct {
    int          due;
    int          addr;
    logic [31:0] data;
  } wr_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model
  wr_t         wq[$];
  int          exp_occ   = 0;
  bit          exp_err   = 1'b0;
  int          exp_slot  = 0;
  int          word_idx  = 0;
  int          gen_left  = 0;
  logic [31:0] gen_data  = '0;
  bit          in_flight = 1'b0;
  int          pd_due    = -1;
  bit          rst_prev  = 1'b1;
  bit          idle_prev = 1'b0;
  bit          en_prev   = 1'b0;
  int          occ_prev  = 0;
  int          dut_starts = 0;
  int          dut_pd     = 0;

  // scenario knobs
  bit en          = 1'b0;
  bit rst_req     = 1'b0;
  bit rd_req      = 1'b0;
  bit rd_on_done  = 1'b0;
  bit inj_valid   = 1'b0;
  int gap_word    = -1;
  int gap_len     = 0;
  int gap_pct     = 0;
  int rst_at_word = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check this cycle's outputs, then drive the next inputs.
  task automatic step();
    bit          exp_we;
    bit          exp_gs;
    bit          pd_now;
    bit          idle_now;
    bit          rd;
    bit          v;
    bit          do_rst;
    logic [31:0] d;
    int          occ_now;
    @(negedge i_clk);
    cyc++;
    pd_now = (pd_due == cyc);
    exp_gs = 1'b0;
    if (rst_prev) begin
      chk("rst_we",    64'(o_ram_we),    64'(0));
      chk("rst_addr",  64'(o_ram_addr),  64'(0));
      chk("rst_wdata", 64'(o_ram_wdata), 64'(0));
      chk("rst_start", 64'(o_gen_start), 64'(0));
      chk("rst_done",  64'(o_pkt_done),  64'(0));
      chk("rst_occ",   64'(o_occupancy), 64'(0));
      chk("rst_full",  64'(o_full),      64'(0));
      chk("rst_busy",  64'(o_busy),      64'(0));
      chk("rst_err",   64'(o_err),       64'(0));
`ifdef RAM_WR_PARITY_EN
      chk("rst_wpar",  64'(o_ram_wpar),  64'(0));
`endif
    end else begin
      if (o_gen_start) dut_starts++;
      if (o_pkt_done)  dut_pd++;
      exp_gs = idle_prev && en_prev && (occ_prev < NUM_SLOTS);
      chk("gen_start", 64'(o_gen_start), 64'(exp_gs));
      if (exp_gs) in_flight = 1'b1;
      chk("busy", 64'(o_busy), 64'(in_flight));
      exp_we = (wq.size() > 0) && (wq[0].due == cyc);
      chk("we", 64'(o_ram_we), 64'(exp_we));
      if (exp_we) begin
        wr_t w;
        w = wq.pop_front();
        if (o_ram_we) begin
          chk("addr",  64'(o_ram_addr),  64'(w.addr));
          chk("wdata", 64'(o_ram_wdata), 64'(w.data));
`ifdef RAM_WR_PARITY_EN
          chk("wpar",  64'(o_ram_wpar),  64'(^w.data));
`endif
        end
      end
      chk("pkt_done", 64'(o_pkt_done),  64'(pd_now));
      chk("occ",      64'(o_occupancy), 64'(exp_occ));
      chk("full",     64'(o_full),      64'(exp_occ == NUM_SLOTS));
      chk("err",      64'(o_err),       64'(exp_err));
    end
    if (pd_now) in_flight = 1'b0;
    idle_now = !in_flight && !pd_now;
    occ_now  = exp_occ;

    // drive
    do_rst  = rst_req;
    rst_req = 1'b0;
    if (gen_left > 0 && word_idx == rst_at_word) begin
      do_rst      = 1'b1;
      rst_at_word = -1;
    end
    v  = 1'b0;
    d  = '0;
    rd = 1'b0;
    if (!do_rst) begin
      if (gen_left > 0) begin
        bit gap;
        gap = 1'b0;
        if (word_idx == gap_word && gap_len > 0) begin
          gap = 1'b1;
          gap_len--;
        end else if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
          gap = 1'b1;
        end
        if (!gap) begin
          v = 1'b1;
          d = gen_data;
          wq.push_back('{cyc + 1, exp_slot * PKT_LEN + word_idx, gen_data});
          gen_data++;
          word_idx++;
          gen_left--;
          if (gen_left == 0) begin
            pd_due   = cyc + 1;
            word_idx = 0;
            exp_slot = (exp_slot + 1) % NUM_SLOTS;
          end
        end
      end else if (inj_valid) begin
        v         = 1'b1;
        d         = 32'hdead_beef;
        inj_valid = 1'b0;
        exp_err   = 1'b1;
      end
      rd     = rd_req || (rd_on_done && pd_now);
      rd_req = 1'b0;
      if (pd_now && !rd) begin
        exp_occ++;
      end else if (rd && !pd_now) begin
        if (exp_occ > 0) exp_occ--;
        else exp_err = 1'b1;
      end
      if (exp_gs) gen_left = PKT_LEN;
    end else begin
      wq.delete();
      exp_occ   = 0;
      exp_err   = 1'b0;
      exp_slot  = 0;
      word_idx  = 0;
      gen_left  = 0;
      gen_data  = '0;
      in_flight = 1'b0;
      pd_due    = -1;
      idle_now  = 1'b1;
      occ_now   = 0;
    end
    i_rst        = do_rst;
    i_enable     = en;
    i_rd_done    = rd;
    i_data_valid = v;
    i_data       = d;
    rst_prev     = do_rst;
    en_prev      = en;
    occ_prev     = occ_now;
    idle_prev    = idle_now;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step();
    step();
  endtask

  task automatic wait_pd(input int target, input int budget);
    int b;
    b = budget;
    while (dut_pd < target && b > 0) begin
      step();
      b--;
    end
    chk("pd_wait", 64'(dut_pd), 64'(target));
  endtask

  initial begin
    int s0;
    int b;
    i_rst        = 1'b1;
    i_enable     = 1'b0;
    i_rd_done    = 1'b0;
    i_data_valid = 1'b0;
    i_data       = '0;

    // single packet, then fill to full
    do_reset();
    en = 1'b1;
    wait_pd(1, 300);
    step();
    chk("occ_one", 64'(o_occupancy), 64'(1));
    wait_pd(4, 1200);
    run(200);
    chk("full_hold",   64'(o_full),     64'(1));
    chk("starts_four", 64'(dut_starts), 64'(4));

    // wrap into slot 0 and release in the same cycle as pkt_done
    rd_req     = 1'b1;
    rd_on_done = 1'b1;
    wait_pd(5, 400);
    en         = 1'b0;
    rd_on_done = 1'b0;
    step();
    chk("occ_simul", 64'(o_occupancy), 64'(3));
    run(20);

    // valid gap at word 10
    do_reset();
    gap_word = 10;
    gap_len  = 3;
    en       = 1'b1;
    wait_pd(dut_pd + 1, 400);
    en = 1'b0;
    gap_word = -1;
    run(5);
    chk("gap_occ", 64'(o_occupancy), 64'(1));

    // enable dropped mid-packet
    s0 = dut_starts;
    en = 1'b1;
    b  = 300;
    while (word_idx < 20 && b > 0) begin
      step();
      b--;
    end
    en = 1'b0;
    wait_pd(dut_pd + 1, 300);
    run(100);
    chk("en_drop_starts", 64'(dut_starts - s0), 64'(1));

    // protocol errors
    inj_valid = 1'b1;
    run(2);
    chk("err_idle", 64'(o_err), 64'(1));
    run(10);
    chk("err_sticky", 64'(o_err), 64'(1));
    do_reset();
    rd_req = 1'b1;
    run(2);
    chk("err_underflow", 64'(o_err),       64'(1));
    chk("occ_underflow", 64'(o_occupancy), 64'(0));

    // reset mid-packet, next packet restarts at slot 0
    do_reset();
    en          = 1'b1;
    rst_at_word = 30;
    wait_pd(dut_pd + 1, 500);
    en = 1'b0;
    run(10);
    chk("occ_after_abort", 64'(o_occupancy), 64'(1));

    // randomized traffic
    do_reset();
    gap_pct = 20;
    en      = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(199) == 0) en = !en;
      if ($urandom_range(59) == 0) rd_req = 1'b1;
      rd_on_done = ($urandom_range(3) == 0);
      step();
    end
    en         = 1'b0;
    rd_on_done = 1'b0;
    run(150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
